cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/instr_dec.sv | 27 ++
 rtl/cpu_controller.sv | 132 +++++++++++++
 tb/tb_cpu_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU controller: FSM state encoding, opcode/op
// constants and writeback-select codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WR_IMM = 3'd2,
    S_GET_A  = 3'd3,
    S_GET_B  = 3'd4,
    S_ALU    = 3'd5,
    S_WR_REG = 3'd6
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

  function automatic logic is_mov_reg(input logic [2:0] opcode, input logic [1:0] op);
    return (opcode == OPC_MOV) && (op == OP_MOV_REG);
  endfunction

endpackage

// File: rtl/instr_dec.sv
// Instruction field extraction and immediate sign extension; purely
// combinational from the captured instruction register.
module instr_dec #(
  parameter int IW = 16
) (
  input  logic [IW-1:0] ir,
  output logic [2:0]    opcode,
  output logic [1:0]    op,
  output logic [2:0]    rn,
  output logic [2:0]    rd,
  output logic [1:0]    sh,
  output logic [2:0]    rm,
  output logic [IW-1:0] sximm8,
  output logic [IW-1:0] sximm5
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign sximm8 = {{(IW-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(IW-5){ir[4]}}, ir[4:0]};

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle datapath controller: holds the instruction register and
// sequences register reads, ALU operation and writeback as a Moore FSM.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [IW-1:0] in,
  input  logic          load,
  input  logic          s,
  output logic          w,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    vsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [IW-1:0] sximm8,
  output logic [IW-1:0] sximm5
);

  state_t        state, next_state;
  logic [IW-1:0] ir;
  logic [2:0]    opcode, rn, rd, rm;
  logic [1:0]    op, sh;
  logic          mov_reg;

  instr_dec #(.IW(IW)) u_dec (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm8 (sximm8),
    .sximm5 (sximm5)
  );

  assign mov_reg = is_mov_reg(opcode, op);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
    end else begin
      state <= next_state;
    end
  end

  // The IR only changes between instructions so every strobe sees stable fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir <= '0;
    end else if (load && (state == S_WAIT)) begin
      ir <= in;
    end
  end

  always_comb begin
    next_state = state;
    readnum    = 3'd0;
    writenum   = 3'd0;
    write      = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    vsel       = VSEL_MDATA;
    shift      = 2'b00;
    ALUop      = 2'b00;
    case (state)
      S_WAIT: begin
        if (s) next_state = S_DECODE;
      end
      S_DECODE: begin
        if ((opcode == OPC_MOV) && (op == OP_MOV_IMM)) next_state = S_WR_IMM;
        else if (mov_reg)                               next_state = S_GET_B;
        else if (opcode == OPC_ALU)                     next_state = (op == OP_MVN) ? S_GET_B : S_GET_A;
        else                                            next_state = S_WAIT;
      end
      S_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        next_state = S_GET_B;
      end
      S_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        next_state = S_ALU;
      end
      S_ALU: begin
        shift = sh;
        asel  = mov_reg;
        ALUop = mov_reg ? 2'b00 : op;
        // CMP only updates status; nothing is written back.
        if ((opcode == OPC_ALU) && (op == OP_CMP)) begin
          loads      = 1'b1;
          next_state = S_WAIT;
        end else begin
          loadc      = 1'b1;
          next_state = S_WR_REG;
        end
      end
      S_WR_REG: begin
        write      = 1'b1;
        vsel       = VSEL_C;
        writenum   = rd;
        next_state = S_WAIT;
      end
      S_WR_IMM: begin
        write      = 1'b1;
        vsel       = VSEL_IMM8;
        writenum   = rn;
        next_state = S_WAIT;
      end
      default: next_state = S_WAIT;
    endcase
  end

  assign w = (state == S_WAIT);

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: walks each instruction class cycle by
// cycle and compares the full control vector against hand-computed values.
module tb_cpu_controller;

  logic        clk;
  logic        reset_n;
  logic [15:0] in_w;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, shift, alu_op;
  logic [15:0] sximm8, sximm5;

  int errors = 0;
  int checks = 0;

  cpu_controller #(.IW(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (in_w),
    .load     (load),
    .s        (s),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .vsel     (vsel),
    .shift    (shift),
    .ALUop    (alu_op),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, ALUop}
  logic [19:0] obs_v;
  assign obs_v = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                  asel, bsel, vsel, shift, alu_op};

  function automatic logic [19:0] ev(
    input logic ww, input logic [2:0] rn, input logic [2:0] wn,
    input logic wr, input logic la, input logic lb, input logic lc, input logic ls,
    input logic as, input logic bs, input logic [1:0] vs, input logic [1:0] sh,
    input logic [1:0] al);
    return {ww, rn, wn, wr, la, lb, lc, ls, as, bs, vs, sh, al};
  endfunction

  task automatic chk(input string tag, input logic [19:0] exp);
    checks++;
    assert (obs_v === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs_v, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change at negedge, outputs sampled after it
  task automatic load_ir(input logic [15:0] val);
    in_w = val;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic start();
    s = 1'b1;
    @(negedge clk);
    s = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [19:0] idle_v, zero_v;

  initial begin
    idle_v  = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    zero_v  = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    reset_n = 1'b0;
    in_w    = 16'h0000;
    load    = 1'b0;
    s       = 1'b0;

    #3;
    chk("reset_outs", idle_v);
    chk16("reset_sximm8", sximm8, 16'h0000);
    chk16("reset_sximm5", sximm5, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    cyc();
    chk("idle_no_s", idle_v);

    // MOV R0,#7
    load_ir(16'hD007);
    chk16("mov_imm_sximm8", sximm8, 16'h0007);
    chk16("mov_imm_sximm5", sximm5, 16'h0007);
    start();
    chk("mov_imm_decode", zero_v);
    cyc();
    chk("mov_imm_wr", ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00));
    cyc();
    chk("mov_imm_done", idle_v);

    // ADD R2,R1,R0 LSL#1 with a load attempt during GET_B
    load_ir(16'hA148);
    start();
    chk("add_decode", zero_v);
    cyc();
    chk("add_get_a", ev(0, 3'd1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    cyc();
    chk("add_get_b", ev(0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    in_w = 16'hD0FF;
    load = 1'b1;
    cyc();
    load = 1'b0;
    chk("add_alu", ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00));
    chk16("add_ir_kept_sximm8", sximm8, 16'h0048);
    chk16("add_ir_kept_sximm5", sximm5, 16'h0008);
    cyc();
    chk("add_wr", ev(0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00));
    cyc();
    chk("add_done", idle_v);

    // CMP R1,R0
    load_ir(16'hA900);
    start();
    chk("cmp_decode", zero_v);
    cyc();
    chk("cmp_get_a", ev(0, 3'd1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    cyc();
    chk("cmp_get_b", ev(0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    cyc();
    chk("cmp_alu", ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01));
    cyc();
    chk("cmp_done", idle_v);

    // MVN R3,R1
    load_ir(16'hB861);
    start();
    chk("mvn_decode", zero_v);
    cyc();
    chk("mvn_get_b", ev(0, 3'd1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    cyc();
    chk("mvn_alu", ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b11));
    cyc();
    chk("mvn_wr", ev(0, 0, 3'd3, 1, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00));
    cyc();
    chk("mvn_done", idle_v);

    // MOV R5,R2 LSR: asel forced, negative immediates
    load_ir(16'hC0B2);
    chk16("movr_sximm8", sximm8, 16'hFFB2);
    chk16("movr_sximm5", sximm5, 16'hFFF2);
    start();
    chk("movr_decode", zero_v);
    cyc();
    chk("movr_get_b", ev(0, 3'd2, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    cyc();
    chk("movr_alu", ev(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b10, 2'b00));
    cyc();
    chk("movr_wr", ev(0, 0, 3'd5, 1, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00));
    cyc();
    chk("movr_done", idle_v);

    // undefined encoding
    load_ir(16'hE000);
    start();
    chk("bad_decode", zero_v);
    cyc();
    chk("bad_back_wait", idle_v);

    // reset during ADD ALU state
    load_ir(16'hA148);
    start();
    cyc();
    cyc();
    cyc();
    chk("rst_add_alu", ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_outs", idle_v);
    chk16("rst_async_sximm8", sximm8, 16'h0000);
    @(negedge clk);
    chk("rst_held", idle_v);
    reset_n = 1'b1;
    cyc();
    chk("rst_after_1", idle_v);
    cyc();
    chk("rst_after_2", idle_v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time limit
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
